// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle controller.
//   state_e : FSM states
//   cls_e   : decoded instruction class (C_ILL = not a supported instruction)
//   OP_* / FN_* : opcode and R-type funct values
//   ALU_* / EXT_* / SRC_* : datapath control encodings
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  typedef enum logic [3:0] {
    C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_ILL
  } cls_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_OR   = 2'b10;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_DM   = 2'b01;
  localparam logic [1:0] SRC_EXT  = 2'b10;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode.
//   opcode, funct : instruction fields to classify
//   cls           : instruction class
//   illegal       : 1 when the opcode/funct pair is not supported
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output cls_e       cls,
  output logic       illegal
);

  always_comb begin
    cls = C_ILL;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FN_ADDU)      cls = C_ADDU;
        else if (funct == FN_SUBU) cls = C_SUBU;
      end
      OP_ORI:  cls = C_ORI;
      OP_LUI:  cls = C_LUI;
      OP_LW:   cls = C_LW;
      OP_SW:   cls = C_SW;
      OP_BEQ:  cls = C_BEQ;
      OP_J:    cls = C_J;
      default: cls = C_ILL;
    endcase
    illegal = (cls == C_ILL);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences the datapath through
// FETCH/DECODE/EXEC/MEM/WB, gates PC/IR updates, waits on mem_ready with a
// timeout and traps (sticky fault) on illegal instructions or timeouts.
//   clk, rst (async, active low)
//   opcode, funct, zero, mem_ready : from datapath / data memory
//   alu_ctl, ext_op, reg_src, alu_src, reg_dst, reg_write, mem_req,
//   mem_write, npc_sel, j_ctl, pc_write, ir_write : datapath controls
//   fault : sticky trap indicator
//   cycle_cnt, instr_cnt : perf counters, present only when
//     MULTICYCLE_CTRL_PERF_CNT_EN is defined (otherwise tied to 0)
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [1:0]       alu_ctl,
  output logic [1:0]       ext_op,
  output logic [1:0]       reg_src,
  output logic             alu_src,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             mem_req,
  output logic             mem_write,
  output logic             npc_sel,
  output logic             j_ctl,
  output logic             pc_write,
  output logic             ir_write,
  output logic             fault,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d, fn_q, fn_d;
  logic [7:0] wait_q, wait_d;
  cls_e       cls;
  logic       illegal;

  // The branch decision itself is made in the datapath (npc_sel & zero).
  logic unused_zero;
  assign unused_zero = zero;

  // In DECODE the live fields are classified (for the trap decision);
  // afterwards only the latched copy is used.
  logic [5:0] dec_op, dec_fn;
  assign dec_op = (state_q == S_DECODE) ? opcode : op_q;
  assign dec_fn = (state_q == S_DECODE) ? funct  : fn_q;

  ctrl_decode u_dec (
    .opcode  (dec_op),
    .funct   (dec_fn),
    .cls     (cls),
    .illegal (illegal)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    fn_d      = fn_q;
    wait_d    = '0;
    alu_ctl   = ALU_ADD;
    ext_op    = EXT_ZERO;
    reg_src   = SRC_ALU;
    alu_src   = 1'b0;
    reg_dst   = 1'b0;
    reg_write = 1'b0;
    mem_req   = 1'b0;
    mem_write = 1'b0;
    npc_sel   = 1'b0;
    j_ctl     = 1'b0;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    fault     = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        ir_write = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        op_d    = opcode;
        fn_d    = funct;
        state_d = illegal ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        state_d = S_WB;
        case (cls)
          C_SUBU: alu_ctl = ALU_SUB;
          C_ORI: begin
            alu_ctl = ALU_OR;
            alu_src = 1'b1;
          end
          C_LUI: ext_op = EXT_LUI;
          C_LW, C_SW: begin
            ext_op  = EXT_SIGN;
            alu_src = 1'b1;
            state_d = S_MEM;
          end
          C_BEQ: begin
            alu_ctl  = ALU_SUB;
            npc_sel  = 1'b1;
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end
          C_J: begin
            j_ctl    = 1'b1;
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        // Address computation held stable for the whole access.
        mem_req = 1'b1;
        ext_op  = EXT_SIGN;
        alu_src = 1'b1;
        if (mem_ready) begin
          if (cls == C_SW) begin
            mem_write = 1'b1;
            pc_write  = 1'b1;
            state_d   = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == TO_LAST) begin
          state_d = S_TRAP;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
        case (cls)
          C_ADDU, C_SUBU: reg_dst = 1'b1;
          C_LW:           reg_src = SRC_DM;
          C_LUI:          reg_src = SRC_EXT;
          default: ;
        endcase
      end
      S_TRAP:  fault = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      fn_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fn_q    <= fn_d;
      wait_q  <= wait_d;
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  logic [CNT_W-1:0] cyc_q, cyc_d, ins_q, ins_d;

  always_comb begin
    cyc_d = cyc_q;
    ins_d = ins_q;
    if (state_q != S_TRAP) begin
      cyc_d = cyc_q + CNT_ONE;
      if (pc_write) ins_d = ins_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ins_q <= ins_d;
    end
  end

  assign cycle_cnt = cyc_q;
  assign instr_cnt = ins_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM that sequences the single-cycle datapath over several clocks per instruction.
- Decodes opcode/funct, drives every datapath control line, and gates PC/IR updates.
- Waits on a data-memory ready handshake, with a timeout.
- Sits beside the datapath in the CPU top; replaces the combinational controller.

Parameters:
MEM_TIMEOUT, 16, max cycles in MEM waiting for mem_ready before a fault (1..255)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset (0 = in reset)
opcode  in  6  instr[31:26] from datapath
funct  in  6  instr[5:0] from datapath
zero  in  1  ALU zero flag
mem_ready  in  1  data memory completes access this cycle
alu_ctl  out  2  00 add, 01 sub, 10 or, 11 reserved
ext_op  out  2  00 zero-ext, 01 sign-ext, 10 imm<<16
reg_src  out  2  00 ALU, 01 DM, 10 EXT
alu_src  out  1  0 = rt data, 1 = ext imm
reg_dst  out  1  0 = rt field, 1 = rd field
reg_write  out  1  GPR write enable
mem_req  out  1  data memory access request
mem_write  out  1  DM write strobe
npc_sel  out  1  branch select for next PC
j_ctl  out  1  jump select for next PC
pc_write  out  1  PC update enable
ir_write  out  1  IR load enable
fault  out  1  sticky: illegal instruction or memory timeout
cycle_cnt  out  CNT_W  cycles since reset (optional)
instr_cnt  out  CNT_W  retired instructions (optional)

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Reset (rst=0, async): state=IDLE, fault=0, counters=0, all outputs 0.
- IDLE: all enables 0. Next state FETCH unconditionally.
- FETCH: ir_write=1. Next state DECODE.
- DECODE: latch opcode/funct into internal regs; all later states use the latched values. Next state EXEC.
- Legal instructions:
  - R-type (opcode 000000) addu funct 100001, subu funct 100011
  - ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010
- Any other opcode/funct in DECODE -> TRAP.
- EXEC drives ALU/ext controls:
  - addu: alu_ctl=00, alu_src=0
  - subu: alu_ctl=01, alu_src=0
  - ori: alu_ctl=10, ext_op=00, alu_src=1
  - lw/sw: alu_ctl=00, ext_op=01, alu_src=1
  - beq: alu_ctl=01, alu_src=0
  - lui: ext_op=10
- Transitions out of EXEC:
  - beq: pc_write=1, npc_sel=1 (PC takes the branch target iff zero); next FETCH
  - j: pc_write=1, j_ctl=1; next FETCH
  - lw/sw: next MEM
  - others: next WB
- MEM:
  - mem_req=1 every cycle; ALU controls held.
  - sw: mem_write=1 only in the cycle mem_ready=1.
  - On mem_ready=1: sw -> pc_write=1, next FETCH; lw -> next WB.
  - Wait counter increments each MEM cycle with mem_ready=0. Reaching MEM_TIMEOUT -> TRAP.
- WB: reg_write=1 and pc_write=1 (sequential PC).
  - R-type: reg_dst=1, reg_src=00
  - ori: reg_dst=0, reg_src=00
  - lw: reg_dst=0, reg_src=01
  - lui: reg_dst=0, reg_src=10
  - Next state FETCH.
- Latency in cycles: beq/j 3, R/ori/lui 4, sw 4+wait, lw 5+wait.
- pc_write is asserted exactly once per instruction, in its final cycle.
- TRAP: fault=1 sticky, all enables 0, held until reset. Reset asserted mid-instruction aborts it without a write.
- Control signals not listed for a state are 0. No write enable is ever asserted in IDLE, DECODE or TRAP.

Optional Feature:
- Macro MULTICYCLE_CTRL_PERF_CNT_EN.
- Defined:
  - cycle_cnt increments every clock out of reset.
  - instr_cnt increments on every pc_write.
  - Both wrap modulo 2^CNT_W and freeze in TRAP.
- Undefined: both outputs tied to 0 and no counter flops synthesised.

Decomposition:
- Package ctrl_pkg:
  - state enum
  - opcode/funct constants
  - alu_ctl, ext_op and reg_src encodings
- Sub-module ctrl_decode: combinational decode of the latched opcode/funct into instruction class plus illegal flag.
- FSM, wait counter and perf counters stay in multicycle_ctrl.

Test Plan:
- Release reset, then addu (op 0, funct 100001), mem_ready=1 -> IDLE, FETCH, DECODE, EXEC(alu_ctl=00), WB with reg_write=1, reg_dst=1, pc_write=1; next FETCH 5 cycles after reset release.
- beq with zero=1, then j -> each takes 3 cycles; pc_write with npc_sel=1 in beq EXEC, pc_write with j_ctl=1 in j EXEC.
- lw with mem_ready low 3 cycles then high -> mem_req held 4 cycles, then WB with reg_src=01, reg_dst=0; 8 cycles total.
- sw with mem_ready high on first MEM cycle -> mem_write one cycle, reg_write never 1, pc_write in that MEM cycle.
- Illegal opcode 111111, and separately lw with mem_ready stuck 0 for 16 cycles -> TRAP, fault=1, all enables 0; rst pulse clears fault and returns to IDLE.
- With MULTICYCLE_CTRL_PERF_CNT_EN: addu+beq+lw(no wait) -> instr_cnt=3, cycle_cnt=4+3+5+1=13 at the 2nd FETCH after lw.
